odma_lite_master: RTL and testbench

- AXI4-Lite initiator that converts single-beat register commands into AXI-Lite read or write transactions.
- Drives the m_lite_* master port that the action shell exposes toward the host register space. It is the initiating end for the lite responder side.
- Only one transaction is outstanding at a time.
- Includes a response timeout so that a hung responder cannot stall the command source.

---
 rtl/odma_lite_pkg.sv | 20 ++
 rtl/odma_lite_master.sv | 210 +++++++++++++++++++++
 tb/tb_odma_lite_master.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/odma_lite_pkg.sv
// rtl/odma_lite_pkg.sv - shared types and constants for the AXI4-Lite command initiator
// Contents:
//   state_t      - controller state encoding
//   RESP_OKAY    - AXI OKAY response code
//   RESP_SLVERR  - AXI SLVERR response code, also reported on timeout
package odma_lite_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_RESP,
        ST_DRAIN
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/odma_lite_master.sv
// rtl/odma_lite_master.sv - single-outstanding AXI4-Lite initiator driven by register commands
// Ports:
//   clk, rst_n                          - clock, asynchronous active-low reset
//   cmd_valid/ready/write/addr/wdata/wstrb - command input (one command at a time)
//   rsp_valid/ready/rdata/resp/timeout  - response output, held until consumed
//   m_lite_aw*, m_lite_w*, m_lite_b*    - AXI4-Lite write channels (master side)
//   m_lite_ar*, m_lite_r*               - AXI4-Lite read channels (master side)
module odma_lite_master
    import odma_lite_pkg::*;
#(
    parameter int AXIL_ADDR_WIDTH = 32,
    parameter int AXIL_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES  = 1024,
    parameter int TIMEOUT_W       = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,

    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_write,
    input  logic [AXIL_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [AXIL_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [AXIL_DATA_WIDTH/8-1:0] cmd_wstrb,

    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [AXIL_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                   rsp_resp,
    output logic                         rsp_timeout,

    output logic                         m_lite_awvalid,
    output logic [AXIL_ADDR_WIDTH-1:0]   m_lite_awaddr,
    input  logic                         m_lite_awready,
    output logic                         m_lite_wvalid,
    output logic [AXIL_DATA_WIDTH-1:0]   m_lite_wdata,
    output logic [AXIL_DATA_WIDTH/8-1:0] m_lite_wstrb,
    input  logic                         m_lite_wready,
    input  logic                         m_lite_bvalid,
    input  logic [1:0]                   m_lite_bresp,
    output logic                         m_lite_bready,
    output logic                         m_lite_arvalid,
    output logic [AXIL_ADDR_WIDTH-1:0]   m_lite_araddr,
    input  logic                         m_lite_arready,
    input  logic                         m_lite_rvalid,
    input  logic [AXIL_DATA_WIDTH-1:0]   m_lite_rdata,
    input  logic [1:0]                   m_lite_rresp,
    output logic                         m_lite_rready
);

    localparam logic [TIMEOUT_W:0] TIMEOUT_LIMIT = (TIMEOUT_W + 1)'(TIMEOUT_CYCLES);

    state_t               state;
    logic [TIMEOUT_W-1:0] cnt;

    logic aw_fire, w_fire, ar_fire, b_fire, r_fire;
    logic wr_req_done;
    logic cnt_en;
    logic timeout_hit;
    logic real_done;
    logic timeout_now;

    assign aw_fire = m_lite_awvalid & m_lite_awready;
    assign w_fire  = m_lite_wvalid  & m_lite_wready;
    assign ar_fire = m_lite_arvalid & m_lite_arready;
    assign b_fire  = m_lite_bvalid  & m_lite_bready;
    assign r_fire  = m_lite_rvalid  & m_lite_rready;

    // The last outstanding AW/W beat completes this cycle (either order, or both at once).
    assign wr_req_done = (m_lite_awvalid | m_lite_wvalid)
                       & (~m_lite_awvalid | m_lite_awready)
                       & (~m_lite_wvalid  | m_lite_wready);

    assign cnt_en = (state == ST_WR_REQ) || (state == ST_WR_RESP) ||
                    (state == ST_RD_REQ) || (state == ST_RD_RESP);

    // Fires on the edge at which the counter would reach the limit.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                         (({1'b0, cnt} + (TIMEOUT_W + 1)'(1)) >= TIMEOUT_LIMIT);

    // A real response arriving on the timeout edge takes priority.
    assign real_done = ((state == ST_WR_RESP) && b_fire) ||
                       ((state == ST_RD_RESP) && r_fire);

    assign timeout_now = cnt_en && timeout_hit && !real_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            cmd_ready      <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_resp       <= RESP_OKAY;
            rsp_timeout    <= 1'b0;
            m_lite_awvalid <= 1'b0;
            m_lite_awaddr  <= '0;
            m_lite_wvalid  <= 1'b0;
            m_lite_wdata   <= '0;
            m_lite_wstrb   <= '0;
            m_lite_bready  <= 1'b0;
            m_lite_arvalid <= 1'b0;
            m_lite_araddr  <= '0;
            m_lite_rready  <= 1'b0;
        end else begin
            // Channel handshakes are handled outside the state case so that
            // DRAIN completes pending beats exactly like the normal path.
            if (aw_fire) begin
                m_lite_awvalid <= 1'b0;
            end
            if (w_fire) begin
                m_lite_wvalid <= 1'b0;
            end
            if (wr_req_done) begin
                m_lite_bready <= 1'b1;
            end
            if (ar_fire) begin
                m_lite_arvalid <= 1'b0;
                m_lite_rready  <= 1'b1;
            end

            if (rsp_valid && rsp_ready) begin
                rsp_valid   <= 1'b0;
                rsp_rdata   <= '0;
                rsp_resp    <= RESP_OKAY;
                rsp_timeout <= 1'b0;
            end

            if (cnt_en && (cnt != '1)) begin
                cnt <= cnt + 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready     <= 1'b0;
                        cnt           <= '0;
                        m_lite_awaddr <= cmd_addr;
                        m_lite_araddr <= cmd_addr;
                        m_lite_wdata  <= cmd_wdata;
                        m_lite_wstrb  <= cmd_wstrb;
                        if (cmd_write) begin
                            m_lite_awvalid <= 1'b1;
                            m_lite_wvalid  <= 1'b1;
                            state          <= ST_WR_REQ;
                        end else begin
                            m_lite_arvalid <= 1'b1;
                            state          <= ST_RD_REQ;
                        end
                    end else begin
                        // Open for commands once the previous response is gone.
                        cmd_ready <= !rsp_valid || rsp_ready;
                    end
                end
                ST_WR_REQ: begin
                    if (wr_req_done) begin
                        state <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (b_fire) begin
                        rsp_valid     <= 1'b1;
                        rsp_rdata     <= '0;
                        rsp_resp      <= m_lite_bresp;
                        rsp_timeout   <= 1'b0;
                        m_lite_bready <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                ST_RD_REQ: begin
                    if (ar_fire) begin
                        state <= ST_RD_RESP;
                    end
                end
                ST_RD_RESP: begin
                    if (r_fire) begin
                        rsp_valid     <= 1'b1;
                        rsp_rdata     <= m_lite_rdata;
                        rsp_resp      <= m_lite_rresp;
                        rsp_timeout   <= 1'b0;
                        m_lite_rready <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    // Late beats are accepted and thrown away.
                    if (b_fire) begin
                        m_lite_bready <= 1'b0;
                        state         <= ST_IDLE;
                    end else if (r_fire) begin
                        m_lite_rready <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            if (timeout_now) begin
                rsp_valid   <= 1'b1;
                rsp_timeout <= 1'b1;
                rsp_resp    <= RESP_SLVERR;
                rsp_rdata   <= '0;
                state       <= ST_DRAIN;
            end
        end
    end

endmodule

// File: tb/tb_odma_lite_master.sv
// tb/tb_odma_lite_master.sv - testbench for odma_lite_master
module tb_odma_lite_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [SW-1:0] cmd_wstrb = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          rsp_timeout;
    logic          m_lite_awvalid;
    logic [AW-1:0] m_lite_awaddr;
    logic          m_lite_awready = 1'b0;
    logic          m_lite_wvalid;
    logic [DW-1:0] m_lite_wdata;
    logic [SW-1:0] m_lite_wstrb;
    logic          m_lite_wready = 1'b0;
    logic          m_lite_bvalid = 1'b0;
    logic [1:0]    m_lite_bresp = 2'b00;
    logic          m_lite_bready;
    logic          m_lite_arvalid;
    logic [AW-1:0] m_lite_araddr;
    logic          m_lite_arready = 1'b0;
    logic          m_lite_rvalid = 1'b0;
    logic [DW-1:0] m_lite_rdata = '0;
    logic [1:0]    m_lite_rresp = 2'b00;
    logic          m_lite_rready;

    odma_lite_master #(
        .AXIL_ADDR_WIDTH(AW),
        .AXIL_DATA_WIDTH(DW),
        .TIMEOUT_CYCLES (TO),
        .TIMEOUT_W      (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .cmd_wstrb     (cmd_wstrb),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .rsp_timeout   (rsp_timeout),
        .m_lite_awvalid(m_lite_awvalid),
        .m_lite_awaddr (m_lite_awaddr),
        .m_lite_awready(m_lite_awready),
        .m_lite_wvalid (m_lite_wvalid),
        .m_lite_wdata  (m_lite_wdata),
        .m_lite_wstrb  (m_lite_wstrb),
        .m_lite_wready (m_lite_wready),
        .m_lite_bvalid (m_lite_bvalid),
        .m_lite_bresp  (m_lite_bresp),
        .m_lite_bready (m_lite_bready),
        .m_lite_arvalid(m_lite_arvalid),
        .m_lite_araddr (m_lite_araddr),
        .m_lite_arready(m_lite_arready),
        .m_lite_rvalid (m_lite_rvalid),
        .m_lite_rdata  (m_lite_rdata),
        .m_lite_rresp  (m_lite_rresp),
        .m_lite_rready (m_lite_rready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Responder configuration: wait cycles before each ready/valid, response payloads.
    int          aw_lat = 0, w_lat = 0, b_lat = 0, ar_lat = 0, r_lat = 0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    logic [31:0] cfg_rdata = '0;

    // Responder state and observations.
    int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    bit          aw_got = 0, w_got = 0, b_pend = 0, r_pend = 0;
    int          aw_beats = 0, w_beats = 0, b_beats = 0, ar_beats = 0, r_beats = 0;
    logic [31:0] got_awaddr = '0, got_wdata = '0, got_araddr = '0;
    logic [3:0]  got_wstrb = '0;
    bit          aw_stall = 0, w_stall = 0, ar_stall = 0;
    bit          aw_fired = 0, w_fired = 0, ar_fired = 0;
    logic [31:0] hold_awaddr = '0, hold_wdata = '0, hold_araddr = '0;
    logic [3:0]  hold_wstrb = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
            aw_stall = 0; w_stall = 0; ar_stall = 0;
            aw_fired = 0; w_fired = 0; ar_fired = 0;
        end else begin
            // Protocol rules: a stalled beat holds its payload, a beat drops after its handshake,
            // bready only once both AW and W of the current write are done.
            if (aw_stall) chk("aw_stable", {m_lite_awvalid, m_lite_awaddr}, {1'b1, hold_awaddr});
            if (w_stall)  chk("w_stable", {m_lite_wvalid, m_lite_wdata, m_lite_wstrb}, {1'b1, hold_wdata, hold_wstrb});
            if (ar_stall) chk("ar_stable", {m_lite_arvalid, m_lite_araddr}, {1'b1, hold_araddr});
            if (aw_fired) chk("aw_drop", m_lite_awvalid, 0);
            if (w_fired)  chk("w_drop", m_lite_wvalid, 0);
            if (ar_fired) chk("ar_drop", m_lite_arvalid, 0);
            if (m_lite_bready) chk("bready_order", {aw_beats == w_beats, w_beats == b_beats + 1}, 2'b11);

            if (m_lite_bvalid && m_lite_bready) begin
                b_beats++; b_pend = 0; b_cnt = 0;
            end else if (b_pend) b_cnt++;
            if (m_lite_awvalid && m_lite_awready) begin
                aw_beats++; got_awaddr = m_lite_awaddr; aw_got = 1; aw_cnt = 0;
            end else if (m_lite_awvalid) aw_cnt++;
            if (m_lite_wvalid && m_lite_wready) begin
                w_beats++; got_wdata = m_lite_wdata; got_wstrb = m_lite_wstrb; w_got = 1; w_cnt = 0;
            end else if (m_lite_wvalid) w_cnt++;
            if (aw_got && w_got) begin
                b_pend = 1; b_cnt = 0; aw_got = 0; w_got = 0;
            end
            if (m_lite_rvalid && m_lite_rready) begin
                r_beats++; r_pend = 0; r_cnt = 0;
            end else if (r_pend) r_cnt++;
            if (m_lite_arvalid && m_lite_arready) begin
                ar_beats++; got_araddr = m_lite_araddr; r_pend = 1; r_cnt = 0; ar_cnt = 0;
            end else if (m_lite_arvalid) ar_cnt++;

            aw_stall = m_lite_awvalid && !m_lite_awready;
            w_stall  = m_lite_wvalid && !m_lite_wready;
            ar_stall = m_lite_arvalid && !m_lite_arready;
            aw_fired = m_lite_awvalid && m_lite_awready;
            w_fired  = m_lite_wvalid && m_lite_wready;
            ar_fired = m_lite_arvalid && m_lite_arready;
            hold_awaddr = m_lite_awaddr;
            hold_wdata  = m_lite_wdata;
            hold_wstrb  = m_lite_wstrb;
            hold_araddr = m_lite_araddr;
        end
        #1;
        m_lite_awready = rst_n && m_lite_awvalid && (aw_cnt >= aw_lat);
        m_lite_wready  = rst_n && m_lite_wvalid && (w_cnt >= w_lat);
        m_lite_bvalid  = rst_n && b_pend && (b_cnt >= b_lat);
        m_lite_bresp   = cfg_bresp;
        m_lite_arready = rst_n && m_lite_arvalid && (ar_cnt >= ar_lat);
        m_lite_rvalid  = rst_n && r_pend && (r_cnt >= r_lat);
        m_lite_rdata   = cfg_rdata;
        m_lite_rresp   = cfg_rresp;
    end

    int exp_aw = 0, exp_w = 0, exp_b = 0, exp_ar = 0, exp_r = 0;

    task automatic set_cfg(input int a, input int w, input int b, input int ar, input int r,
                           input logic [1:0] br, input logic [1:0] rr, input logic [31:0] rd);
        aw_lat = a; w_lat = w; b_lat = b; ar_lat = ar; r_lat = r;
        cfg_bresp = br; cfg_rresp = rr; cfg_rdata = rd;
    endtask

    // One command end to end against the reference model.
    // Latency is counted in clock edges after the accepting edge.
    task automatic do_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int hold, input bit stall_cmd);
        int raw, exp_n, n, k, a, exp_ready;
        bit exp_to, stable;
        logic [31:0] exp_rdata, snap_rdata;
        logic [1:0]  exp_resp, snap_resp;
        logic        snap_to;

        raw       = wr ? 2 + ((aw_lat > w_lat) ? aw_lat : w_lat) + b_lat : 2 + ar_lat + r_lat;
        exp_to    = raw > TO;
        exp_n     = exp_to ? TO : raw;
        exp_rdata = (wr || exp_to) ? 32'h0 : cfg_rdata;
        exp_resp  = exp_to ? 2'b10 : (wr ? cfg_bresp : cfg_rresp);
        if (wr) begin exp_aw++; exp_w++; exp_b++; end
        else begin exp_ar++; exp_r++; end

        cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb; cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 100) begin @(posedge clk); #1; k++; end
        chk("cmd_ready_before_accept", cmd_ready, 1);
        @(posedge clk); #1;
        a = cyc;
        cmd_valid = 1'b0;
        chk("cmd_ready_after_accept", cmd_ready, 0);
        n = 0;
        while (!rsp_valid && n < 200) begin @(posedge clk); #1; n++; end
        chk("rsp_latency", 64'(n + 1), 64'(exp_n + 1));
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("rsp_resp_timeout", {rsp_resp, rsp_timeout}, {exp_resp, exp_to});

        snap_rdata = rsp_rdata; snap_resp = rsp_resp; snap_to = rsp_timeout;
        stable = 1'b1;
        if (stall_cmd) cmd_valid = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            if (!rsp_valid || rsp_rdata !== snap_rdata || rsp_resp !== snap_resp || rsp_timeout !== snap_to)
                stable = 1'b0;
            if (stall_cmd && cmd_ready !== 1'b0) stable = 1'b0;
        end
        if (hold > 0) chk("rsp_hold_stable", stable, 1);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_cleared", {rsp_valid, rsp_rdata, rsp_resp, rsp_timeout}, 0);

        // Ready returns once both the response is consumed and any drain has finished.
        exp_ready = ((raw + 1) > (exp_n + hold + 1)) ? raw + 1 : exp_n + hold + 1;
        k = 0;
        while (!cmd_ready && k < 200) begin @(posedge clk); #1; k++; end
        chk("cmd_ready_return_cycle", 64'(cyc - a), 64'(exp_ready));
        chk("beat_counts", {12'(aw_beats), 12'(w_beats), 12'(b_beats), 12'(ar_beats), 12'(r_beats)},
                           {12'(exp_aw), 12'(exp_w), 12'(exp_b), 12'(exp_ar), 12'(exp_r)});
        if (wr) chk("write_payload", {got_awaddr, got_wdata[27:0], got_wstrb}, {addr, data[27:0], strb});
        else    chk("read_addr", got_araddr, addr);
        if (wr) chk("write_data_top", got_wdata[31:28], data[31:28]);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          wr;
        logic [31:0] addr, data;
        int          big;

        // Reset state.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", |{cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
                               m_lite_awvalid, m_lite_awaddr, m_lite_wvalid, m_lite_wdata, m_lite_wstrb,
                               m_lite_bready, m_lite_arvalid, m_lite_araddr, m_lite_rready}, 0);
        rst_n = 1'b1;
        #1;
        chk("cmd_ready_low_at_release", cmd_ready, 0);
        @(posedge clk); #1;
        chk("cmd_ready_after_release", cmd_ready, 1);

        // Zero-wait write.
        set_cfg(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
        do_cmd(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 0, 1'b0);

        // Read with AR held off for 5 cycles.
        set_cfg(0, 0, 0, 5, 0, 2'b00, 2'b00, 32'h12345678);
        do_cmd(1'b0, 32'h204, 32'h0, 4'h0, 0, 1'b0);

        // W before AW, then AW before W.
        set_cfg(4, 0, 0, 0, 0, 2'b01, 2'b00, 32'h0);
        do_cmd(1'b1, 32'h40, 32'hA5A5_0001, 4'h3, 1, 1'b0);
        set_cfg(0, 4, 1, 0, 0, 2'b00, 2'b00, 32'h0);
        do_cmd(1'b1, 32'h44, 32'h5A5A_0002, 4'hC, 0, 1'b0);

        // Responder withholds arready past the timeout, then releases it; the late beat is drained.
        set_cfg(0, 0, 0, 30, 1, 2'b00, 2'b00, 32'hCAFE_F00D);
        do_cmd(1'b0, 32'h300, 32'h0, 4'h0, 0, 1'b0);

        // Write timeout with a late B beat.
        set_cfg(2, 1, 20, 0, 0, 2'b00, 2'b00, 32'h0);
        do_cmd(1'b1, 32'h310, 32'h0BAD_0BAD, 4'h5, 3, 1'b0);

        // Real response on the exact timeout edge wins.
        set_cfg(0, 0, 0, 4, 10, 2'b00, 2'b01, 32'h7777_0001);
        do_cmd(1'b0, 32'h320, 32'h0, 4'h0, 0, 1'b0);

        // Response back-pressure with a waiting command, then the waiting command proceeds.
        set_cfg(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
        do_cmd(1'b1, 32'h400, 32'h1111_2222, 4'hF, 10, 1'b1);
        set_cfg(0, 0, 0, 0, 0, 2'b00, 2'b10, 32'h3333_4444);
        do_cmd(1'b0, 32'h404, 32'h0, 4'h0, 0, 1'b0);

        // Asynchronous reset in the middle of a write request.
        set_cfg(10, 10, 0, 0, 0, 2'b00, 2'b00, 32'h0);
        cmd_write = 1'b1; cmd_addr = 32'h500; cmd_wdata = 32'h9999_9999; cmd_wstrb = 4'hF; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk("awvalid_before_reset", {m_lite_awvalid, m_lite_wvalid}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_reset_outputs", |{cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
                                   m_lite_awvalid, m_lite_awaddr, m_lite_wvalid, m_lite_wdata, m_lite_wstrb,
                                   m_lite_bready, m_lite_arvalid, m_lite_araddr, m_lite_rready}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        set_cfg(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0000_BEEF);
        do_cmd(1'b0, 32'h8, 32'h0, 4'h0, 0, 1'b0);

        // Randomized commands, including occasional timeouts.
        for (int i = 0; i < 40; i++) begin
            wr   = 1'($urandom_range(1));
            big  = ($urandom_range(3) == 0) ? 24 : 4;
            set_cfg($urandom_range(big), $urandom_range(big), $urandom_range(big),
                    $urandom_range(big), $urandom_range(big),
                    2'($urandom_range(3)), 2'($urandom_range(3)), $urandom);
            addr = $urandom & 32'hFFFF_FFFC;
            data = $urandom;
            do_cmd(wr, addr, data, 4'($urandom_range(15)), $urandom_range(3), 1'($urandom_range(1)));
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
